m_len_det: RTL
==============

// Module: m_len_det
// PURPOSE
//  Frame-length detector on the write side of the enable/address generator.
//  Counts valid beats between start-of-frame and end-of-frame, classifies the length
//  against the supported Link_id table, and presents a held m_len/link_id/base_addr.
//  The enable generator consumes m_len and starts counting when the value changes.
//  Sits between the input sample framer and the enable generator.
// PARAMETERS
//  CNT_W    13   beat counter / m_len width
//  ADDR_W   16   base_addr width (matches enable generator address width)
// PORTS
//  clk        in   1       system clock
//  n_rst      in   1       asynchronous active-low reset
//  din_valid  in   1       input beat valid
//  din_sof    in   1       first beat of frame (qualified by din_valid)
//  din_eof    in   1       last beat of frame (qualified by din_valid)
//  m_len      out  CNT_W   last accepted frame length, held until next accepted frame
//  link_id    out  5       Link_id of last accepted frame (5,6,7,11,17)
//  base_addr  out  ADDR_W  table base for link_id
//  len_vld    out  1       1-cycle pulse: new accepted length on outputs
//  len_err    out  1       1-cycle pulse: frame rejected (unsupported/aborted/overflow)
//  busy       out  1       1 while a frame is being counted (state CNT)
// BEHAVIOUR
//  Reset: m_len=0, link_id=0, base_addr=0, len_vld=0, len_err=0, busy=0, state IDLE, cnt=0.
//  sof/eof are ignored when din_valid=0; beats with din_valid=0 are not counted.
//  FSM IDLE -> CNT on valid sof (cnt<=1); if eof is in the same beat -> CHECK with len 1.
//  CNT: each valid beat cnt+=1; valid eof -> CHECK with len=cnt+1 registered.
//  CNT: valid sof without eof -> abort: len_err pulse; restart with cnt<=1, stay CNT.
//  CHECK (1 cycle): lookup len -> {link_id, base}; then -> IDLE, or -> CNT if valid sof this cycle.
//  Lookup table (len -> link_id, base_addr):
//    288->5,0x0000; 672->6,0x0120; 1056->7,0x03C0; 432->11,0x07E0; 1872->17,0x0990.
//  Hit: m_len/link_id/base_addr update, len_vld=1 the cycle after CHECK.
//  Miss: len_err=1, outputs keep their previous values.
//  Latency: eof beat at cycle N -> len_vld/len_err at cycle N+2.
//  Identical consecutive lengths: outputs unchanged, len_vld still pulses.
//  Counter saturates at 2^CNT_W-1; a saturated frame is rejected (len_err) at eof.
//  eof in IDLE is ignored with no pulse; len_vld and len_err are never asserted together.
//  Reset mid-frame: immediate return to reset values; the partial frame is discarded.
// STRUCTURE
//  Shared package/header: Link_id codes, base constants (0x0120,0x03C0,0x07E0,0x0990,0x10E0),
//    supported lengths and FSM state encodings, shared with the enable generator.
//  Sub-module len_lut: combinational len -> {hit, link_id, base_addr}, reused by the generator.
// TESTING
//  1. sof + 287 beats + eof (288 beats) -> cycle eof+2: len_vld=1, m_len=288, link_id=5, base=0x0000.
//  2. 1056 beats with din_valid gaps -> m_len=1056, link_id=7, base=0x03C0; gaps not counted.
//  3. 500-beat frame -> len_err=1 at eof+2; m_len/link_id hold their prior values.
//  4. sof at beat 100 of an open frame, then 432 beats -> len_err on abort, then m_len=432, link_id=11.
//  5. Back-to-back 672-beat frames, next sof in the CHECK cycle -> two len_vld pulses; m_len stays 672.
//  6. n_rst low mid-frame (beat 50) -> all outputs 0 and busy=0; the next 1872-beat frame -> link_id=17.

Source files
------------

// File: rtl/m_len_det_pkg.sv
// Shared definitions for the frame-length detector and the enable generator:
// Link_id codes, supported frame lengths, table base addresses and FSM states.
package m_len_det_pkg;

   localparam int CNT_W_DEF  = 13;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [4:0] {
      LINK_NONE = 5'd0,
      LINK_5    = 5'd5,
      LINK_6    = 5'd6,
      LINK_7    = 5'd7,
      LINK_11   = 5'd11,
      LINK_17   = 5'd17
   } link_id_t;

   localparam int LEN_L5  = 288;
   localparam int LEN_L6  = 672;
   localparam int LEN_L7  = 1056;
   localparam int LEN_L11 = 432;
   localparam int LEN_L17 = 1872;

   // Bases are cumulative; BASE_END is the first address past the last table.
   localparam logic [15:0] BASE_L5  = 16'h0000;
   localparam logic [15:0] BASE_L6  = 16'h0120;
   localparam logic [15:0] BASE_L7  = 16'h03C0;
   localparam logic [15:0] BASE_L11 = 16'h07E0;
   localparam logic [15:0] BASE_L17 = 16'h0990;
   localparam logic [15:0] BASE_END = 16'h10E0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CNT   = 2'd1,
      ST_CHECK = 2'd2
   } len_state_t;

endpackage

// File: rtl/m_len_det_if.sv
// Framer-to-detector bundle: beat qualifiers in, held length result and pulses out.
interface m_len_det_if #(
   parameter int CNT_W  = 13,
   parameter int ADDR_W = 16
);
   logic              din_valid;
   logic              din_sof;
   logic              din_eof;
   logic [CNT_W-1:0]  m_len;
   logic [4:0]        link_id;
   logic [ADDR_W-1:0] base_addr;
   logic              len_vld;
   logic              len_err;
   logic              busy;

   modport master (
      output din_valid, din_sof, din_eof,
      input  m_len, link_id, base_addr, len_vld, len_err, busy
   );

   modport slave (
      input  din_valid, din_sof, din_eof,
      output m_len, link_id, base_addr, len_vld, len_err, busy
   );
endinterface

// File: rtl/m_len_det_len_lut.sv
// Combinational frame length -> {hit, link_id, base_addr} lookup.
// Shared with the enable generator so both sides agree on the table.
module m_len_det_len_lut
   import m_len_det_pkg::*;
#(
   parameter int CNT_W  = 13,
   parameter int ADDR_W = 16
) (
   input  logic [CNT_W-1:0]  len,
   output logic              hit,
   output link_id_t          link_id,
   output logic [ADDR_W-1:0] base_addr
);

   always_comb begin
      hit       = 1'b0;
      link_id   = LINK_NONE;
      base_addr = '0;
      case (len)
         CNT_W'(LEN_L5): begin
            hit       = 1'b1;
            link_id   = LINK_5;
            base_addr = ADDR_W'(BASE_L5);
         end
         CNT_W'(LEN_L6): begin
            hit       = 1'b1;
            link_id   = LINK_6;
            base_addr = ADDR_W'(BASE_L6);
         end
         CNT_W'(LEN_L7): begin
            hit       = 1'b1;
            link_id   = LINK_7;
            base_addr = ADDR_W'(BASE_L7);
         end
         CNT_W'(LEN_L11): begin
            hit       = 1'b1;
            link_id   = LINK_11;
            base_addr = ADDR_W'(BASE_L11);
         end
         CNT_W'(LEN_L17): begin
            hit       = 1'b1;
            link_id   = LINK_17;
            base_addr = ADDR_W'(BASE_L17);
         end
         default: begin
            hit       = 1'b0;
            link_id   = LINK_NONE;
            base_addr = '0;
         end
      endcase
   end

endmodule

// File: rtl/m_len_det.sv
// Frame-length detector: counts valid beats from sof to eof, classifies the
// length through len_lut and holds the accepted m_len/link_id/base_addr.
module m_len_det
   import m_len_det_pkg::*;
#(
   parameter int CNT_W  = 13,
   parameter int ADDR_W = 16
) (
   input  logic       clk,
   input  logic       n_rst,
   m_len_det_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   len_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
   logic [CNT_W-1:0]  len_reg, len_next;
   logic              vld_next, err_next, load_next;

   logic [CNT_W-1:0]  m_len_reg;
   logic [4:0]        link_id_reg;
   logic [ADDR_W-1:0] base_reg;
   logic              vld_reg, err_reg;

   logic              lut_hit;
   link_id_t          lut_link;
   logic [ADDR_W-1:0] lut_base;

   logic sof_v, eof_v;
   assign sof_v = bus.din_valid & bus.din_sof;
   assign eof_v = bus.din_valid & bus.din_eof;

   // Saturating increment; a saturated length can never match the table.
   assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_ONE;

   m_len_det_len_lut #(
      .CNT_W  (CNT_W),
      .ADDR_W (ADDR_W)
   ) u_len_lut (
      .len       (len_reg),
      .hit       (lut_hit),
      .link_id   (lut_link),
      .base_addr (lut_base)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (sof_v) state_next = eof_v ? ST_CHECK : ST_CNT;
         end
         ST_CNT: begin
            if (eof_v) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (sof_v) state_next = eof_v ? ST_CHECK : ST_CNT;
            else       state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_next  = cnt_reg;
      len_next  = len_reg;
      vld_next  = 1'b0;
      err_next  = 1'b0;
      load_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (sof_v) begin
               cnt_next = CNT_ONE;
               len_next = CNT_ONE;
            end
         end
         ST_CNT: begin
            if (eof_v) begin
               len_next = cnt_inc;
               cnt_next = '0;
            end else if (sof_v) begin
               // New sof inside an open frame: drop it and restart counting.
               err_next = 1'b1;
               cnt_next = CNT_ONE;
            end else if (bus.din_valid) begin
               cnt_next = cnt_inc;
            end
         end
         ST_CHECK: begin
            vld_next  = lut_hit;
            err_next  = ~lut_hit;
            load_next = lut_hit;
            if (sof_v) begin
               cnt_next = CNT_ONE;
               len_next = CNT_ONE;
            end else begin
               cnt_next = '0;
            end
         end
         default: begin
            cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_reg     <= '0;
         len_reg     <= '0;
         vld_reg     <= 1'b0;
         err_reg     <= 1'b0;
         m_len_reg   <= '0;
         link_id_reg <= '0;
         base_reg    <= '0;
      end else begin
         cnt_reg <= cnt_next;
         len_reg <= len_next;
         vld_reg <= vld_next;
         err_reg <= err_next;
         if (load_next) begin
            m_len_reg   <= len_reg;
            link_id_reg <= lut_link;
            base_reg    <= lut_base;
         end
      end
   end

   assign bus.m_len     = m_len_reg;
   assign bus.link_id   = link_id_reg;
   assign bus.base_addr = base_reg;
   assign bus.len_vld   = vld_reg;
   assign bus.len_err   = err_reg;
   assign bus.busy      = (state_reg == ST_CNT);

endmodule
